// File: rtl/rob_alloc_pkg.sv
// Shared processor parameters used by the ROB, the execution ports and the
// ROB allocator. Also provides the slot-index / occupancy types and a
// modulo increment helper.
package rob_alloc_pkg;
    localparam int ROB_SLOTS      = 16;                  // power of two
    localparam int ROB_IDX_BITS   = $clog2(ROB_SLOTS);
    localparam int ARCH_BITS      = 6;                   // architectural reg index width
    localparam int NUM_CPL_PORTS  = 5;
    localparam int ALMOST_FULL_TH = 2;

    typedef logic [ROB_IDX_BITS-1:0]                     rob_idx_t;
    typedef logic [ROB_IDX_BITS:0]                       rob_cnt_t;
    typedef logic [NUM_CPL_PORTS-1:0][ROB_IDX_BITS-1:0]  cpl_idx_t;

    // Pointer increment; wraps for free because ROB_SLOTS is a power of two.
    function automatic rob_idx_t idx_inc(input rob_idx_t i);
        return i + rob_idx_t'(1);
    endfunction
endpackage

// File: rtl/rob_alloc_if.sv
// Bus between decode / completion ports / ROB (master) and the ROB
// allocator (slave).
//   master drives: clear, allocReq, cplValid, cplIdx, commitValid
//   slave drives : allocGrant, allocIdx, headIdx, headReady, count,
//                  full, almostFull, empty, protoErr
interface rob_alloc_if;
    import rob_alloc_pkg::*;

    logic                     clear;
    logic                     allocReq;
    logic                     allocGrant;
    rob_idx_t                 allocIdx;
    logic [NUM_CPL_PORTS-1:0] cplValid;
    cpl_idx_t                 cplIdx;      // port k at [k*ROB_IDX_BITS +: ROB_IDX_BITS]
    logic                     commitValid;
    rob_idx_t                 headIdx;
    logic                     headReady;
    rob_cnt_t                 count;
    logic                     full;
    logic                     almostFull;
    logic                     empty;
    logic                     protoErr;

    modport master (
        output clear, allocReq, cplValid, cplIdx, commitValid,
        input  allocGrant, allocIdx, headIdx, headReady, count,
               full, almostFull, empty, protoErr
    );

    modport slave (
        input  clear, allocReq, cplValid, cplIdx, commitValid,
        output allocGrant, allocIdx, headIdx, headReady, count,
               full, almostFull, empty, protoErr
    );
endinterface

// File: rtl/rob_alloc_slot_tracker.sv
// Per-slot alloc/done bit vectors for the ROB allocator.
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : flush, wipes both vectors
//   alloc_set_i/idx : mark slot allocated (and not done)
//   cpl_valid_i/idx : NUM_CPL_PORTS completion set ports
//   commit_clr_i/idx: retire slot (clear alloc and done)
//   alloc_o, done_o : current vectors
//   cpl_err_o       : some completion this cycle was illegal (slot not
//                     allocated, already done, or named by two ports)
module rob_alloc_slot_tracker
    import rob_alloc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     alloc_set_i,
    input  rob_idx_t                 alloc_idx_i,
    input  logic [NUM_CPL_PORTS-1:0] cpl_valid_i,
    input  cpl_idx_t                 cpl_idx_i,
    input  logic                     commit_clr_i,
    input  rob_idx_t                 commit_idx_i,
    output logic [ROB_SLOTS-1:0]     alloc_o,
    output logic [ROB_SLOTS-1:0]     done_o,
    output logic                     cpl_err_o
);
    logic [ROB_SLOTS-1:0] alloc_q, alloc_d;
    logic [ROB_SLOTS-1:0] done_q,  done_d;
    logic                 cpl_err;

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        cpl_err = 1'b0;
        for (int k = 0; k < NUM_CPL_PORTS; k++) begin
            if (cpl_valid_i[k]) begin
                // Legality judged on registered state only, so a slot being
                // allocated this very cycle still counts as unallocated.
                if (alloc_q[cpl_idx_i[k]] && !done_q[cpl_idx_i[k]])
                    done_d[cpl_idx_i[k]] = 1'b1;
                else
                    cpl_err = 1'b1;
                for (int j = 0; j < k; j++)
                    if (cpl_valid_i[j] && (cpl_idx_i[j] == cpl_idx_i[k]))
                        cpl_err = 1'b1;
            end
        end
        // A fresh allocation starts out not-done even if a stray completion
        // hit the same slot this cycle.
        if (alloc_set_i) begin
            alloc_d[alloc_idx_i] = 1'b1;
            done_d[alloc_idx_i]  = 1'b0;
        end
        if (commit_clr_i) begin
            alloc_d[commit_idx_i] = 1'b0;
            done_d[commit_idx_i]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
        end
    end

    assign alloc_o   = alloc_q;
    assign done_o    = done_q;
    assign cpl_err_o = cpl_err;
endmodule

// File: rtl/rob_alloc.sv
// ROB allocator: hands out ROB slot indices in program order, mirrors the
// ROB head via commit pulses, tracks occupancy and flags protocol errors.
//   clk, rst : clock, synchronous active-high reset (dominates clear)
//   bus      : rob_alloc_if.slave (alloc handshake, completions, commit,
//              occupancy flags, sticky protoErr)
module rob_alloc
    import rob_alloc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);
    rob_idx_t             tail_q, tail_d;
    rob_idx_t             head_q, head_d;
    rob_cnt_t             count_q, count_d;
    logic                 perr_q, perr_d;

    logic [ROB_SLOTS-1:0] alloc_v, done_v;
    logic                 cpl_err;
    logic                 full, grant, head_ready, commit_ok;
    rob_cnt_t             free_slots;

    // full comes from registered count: a same-cycle commit never frees a
    // slot for a same-cycle grant.
    assign full       = (count_q == rob_cnt_t'(ROB_SLOTS));
    assign free_slots = rob_cnt_t'(ROB_SLOTS) - count_q;
    assign grant      = bus.allocReq & ~full & ~bus.clear & ~rst;
    assign head_ready = alloc_v[head_q] & done_v[head_q];
    assign commit_ok  = bus.commitValid & ~bus.clear & (count_q != '0) & head_ready;

    rob_alloc_slot_tracker u_trk (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (bus.clear),
        .alloc_set_i  (grant),
        .alloc_idx_i  (tail_q),
        .cpl_valid_i  (bus.cplValid),
        .cpl_idx_i    (bus.cplIdx),
        .commit_clr_i (commit_ok),
        .commit_idx_i (head_q),
        .alloc_o      (alloc_v),
        .done_o       (done_v),
        .cpl_err_o    (cpl_err)
    );

    always_comb begin
        tail_d  = grant     ? idx_inc(tail_q) : tail_q;
        head_d  = commit_ok ? idx_inc(head_q) : head_q;
        count_d = count_q;
        case ({grant, commit_ok})
            2'b10:   count_d = count_q + rob_cnt_t'(1);
            2'b01:   count_d = count_q - rob_cnt_t'(1);
            default: count_d = count_q;
        endcase
        perr_d = perr_q | cpl_err | (bus.commitValid & ~commit_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
            perr_q  <= 1'b0;
        end else if (bus.clear) begin
            // Flush: completions/commits this cycle are ignored, error kept.
            tail_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_d;
            head_q  <= head_d;
            count_q <= count_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.allocGrant = grant;
    assign bus.allocIdx   = tail_q;
    assign bus.headIdx    = head_q;
    assign bus.headReady  = head_ready;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.almostFull = (free_slots <= rob_cnt_t'(ALMOST_FULL_TH));
    assign bus.empty      = (count_q == '0);
    assign bus.protoErr   = perr_q;
endmodule

// File: tb/tb_rob_alloc.sv
// Bench for rob_alloc: directed scenarios plus random traffic, compared
// against an in-order queue model of the ROB occupancy.
module tb_rob_alloc;
    import rob_alloc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_alloc_if bus();
    rob_alloc dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: occupied slots as a program-order queue of indices.
    int q[$];
    bit done_m[ROB_SLOTS];
    int tail_m, head_m;
    bit perr_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (done_m[i]) done_m[i] = 0;
        tail_m = 0;
        head_m = 0;
        perr_m = 0;
    endtask

    task automatic idle_inputs();
        bus.clear       = 1'b0;
        bus.allocReq    = 1'b0;
        bus.cplValid    = '0;
        bus.cplIdx      = '0;
        bus.commitValid = 1'b0;
    endtask

    // Called away from the clock edge; leaves time just after a negedge.
    task automatic do_reset();
        idle_inputs();
        bus.allocReq = 1'b1;
        rst = 1'b1;
        #1 chk("rst_grant", bus.allocGrant, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.allocReq = 1'b0;
        model_reset();
    endtask

    // One cycle: drive, check pre-edge outputs vs model, advance model.
    task automatic step(input bit req, input bit [NUM_CPL_PORTS-1:0] cv,
                        input bit [NUM_CPL_PORTS*ROB_IDX_BITS-1:0] ci,
                        input bit cm, input bit clr);
        int  sz, idx;
        bit  hr, grant, err, cm_ok;
        bit  inq[ROB_SLOTS];
        bit  setd[ROB_SLOTS];
        bus.allocReq    = req;
        bus.cplValid    = cv;
        bus.cplIdx      = ci;
        bus.commitValid = cm;
        bus.clear       = clr;
        #1;
        sz    = q.size();
        hr    = (sz > 0) ? done_m[q[0]] : 1'b0;
        grant = req && !clr && (sz < ROB_SLOTS);
        chk("allocGrant", bus.allocGrant, grant);
        chk("allocIdx",   bus.allocIdx,   tail_m);
        chk("headIdx",    bus.headIdx,    head_m);
        chk("headReady",  bus.headReady,  hr);
        chk("count",      bus.count,      sz);
        chk("full",       bus.full,       sz == ROB_SLOTS);
        chk("almostFull", bus.almostFull, (ROB_SLOTS - sz) <= ALMOST_FULL_TH);
        chk("empty",      bus.empty,      sz == 0);
        chk("protoErr",   bus.protoErr,   perr_m);

        if (clr) begin
            q.delete();
            foreach (done_m[i]) done_m[i] = 0;
            tail_m = 0;
            head_m = 0;
        end else begin
            foreach (inq[i]) begin inq[i] = 0; setd[i] = 0; end
            foreach (q[i]) inq[q[i]] = 1;
            err = 0;
            for (int k = 0; k < NUM_CPL_PORTS; k++) begin
                if (cv[k]) begin
                    idx = int'(ci[k*ROB_IDX_BITS +: ROB_IDX_BITS]);
                    if (inq[idx] && !done_m[idx]) setd[idx] = 1;
                    else err = 1;
                    for (int j = 0; j < k; j++)
                        if (cv[j] && int'(ci[j*ROB_IDX_BITS +: ROB_IDX_BITS]) == idx) err = 1;
                end
            end
            cm_ok = cm && hr;
            if (cm && !cm_ok) err = 1;
            foreach (setd[i]) if (setd[i]) done_m[i] = 1;
            if (cm_ok) begin
                done_m[q[0]] = 0;
                void'(q.pop_front());
                head_m = (head_m + 1) % ROB_SLOTS;
            end
            if (grant) begin
                q.push_back(tail_m);
                done_m[tail_m] = 0;
                tail_m = (tail_m + 1) % ROB_SLOTS;
            end
            perr_m = perr_m | err;
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) step(1, '0, '0, 0, 0);
    endtask

    // Complete one slot on a given port.
    task automatic cpl1(input int port, input int idx);
        bit [NUM_CPL_PORTS-1:0] cv;
        bit [NUM_CPL_PORTS*ROB_IDX_BITS-1:0] ci;
        cv = '0;
        ci = '0;
        cv[port] = 1'b1;
        ci[port*ROB_IDX_BITS +: ROB_IDX_BITS] = ROB_IDX_BITS'(idx);
        step(0, cv, ci, 0, 0);
    endtask

    initial begin
        bit [NUM_CPL_PORTS-1:0] cv;
        bit [NUM_CPL_PORTS*ROB_IDX_BITS-1:0] ci;
        int p;

        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk("rst_empty", bus.empty, 1);
        chk("rst_allocIdx", bus.allocIdx, 0);

        // Fill all 16 slots back to back, then a 17th request.
        alloc_n(ROB_SLOTS);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        step(1, '0, '0, 0, 0);

        // Complete everything, 5 ports per cycle.
        for (int b = 0; b < ROB_SLOTS; b += NUM_CPL_PORTS) begin
            cv = '0;
            ci = '0;
            for (int k = 0; k < NUM_CPL_PORTS; k++)
                if (b + k < ROB_SLOTS) begin
                    cv[k] = 1'b1;
                    ci[k*ROB_IDX_BITS +: ROB_IDX_BITS] = ROB_IDX_BITS'(b + k);
                end
            step(0, cv, ci, 0, 0);
        end
        // Commit + alloc while full: no grant, then wrapped grant.
        step(1, '0, '0, 1, 0);
        chk("fullcm_count", bus.count, 15);
        step(1, '0, '0, 0, 0);
        chk("wrap_count", bus.count, 16);
        chk("wrap_tail", bus.allocIdx, 1);

        // Three slots, out-of-order completion, two commits.
        do_reset();
        alloc_n(3);
        cpl1(2, 1);
        chk("hr_before", bus.headReady, 0);
        cpl1(0, 0);
        chk("hr_after", bus.headReady, 1);
        step(0, '0, '0, 1, 0);
        chk("cm1_head", bus.headIdx, 1);
        chk("cm1_count", bus.count, 2);
        step(0, '0, '0, 1, 0);
        chk("cm2_head", bus.headIdx, 2);

        // Completion of an unallocated slot; sticky across clear.
        do_reset();
        cpl1(0, 5);
        chk("unalloc_perr", bus.protoErr, 1);
        step(0, '0, '0, 0, 1);
        chk("clear_perr", bus.protoErr, 1);
        do_reset();
        chk("rst_perr", bus.protoErr, 0);

        // Double completion of idx 3.
        alloc_n(4);
        cpl1(1, 3);
        chk("dbl_ok", bus.protoErr, 0);
        cpl1(3, 3);
        chk("dbl_perr", bus.protoErr, 1);
        chk("dbl_count", bus.count, 4);
        chk("dbl_head", bus.headIdx, 0);

        // Commit while empty.
        do_reset();
        step(0, '0, '0, 1, 0);
        chk("cmE_perr", bus.protoErr, 1);
        chk("cmE_count", bus.count, 0);
        chk("cmE_head", bus.headIdx, 0);

        // Allocate 7, then clear together with allocReq.
        do_reset();
        alloc_n(7);
        step(1, '0, '0, 0, 1);
        chk("clr_idx", bus.allocIdx, 0);
        chk("clr_head", bus.headIdx, 0);
        chk("clr_count", bus.count, 0);
        chk("clr_empty", bus.empty, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cv = '0;
                ci = '0;
                for (int k = 0; k < NUM_CPL_PORTS; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cv[k] = 1'b1;
                        if (q.size() > 0 && $urandom_range(0, 7) != 0)
                            p = q[$urandom_range(0, q.size() - 1)];
                        else
                            p = $urandom_range(0, ROB_SLOTS - 1);
                        ci[k*ROB_IDX_BITS +: ROB_IDX_BITS] = ROB_IDX_BITS'(p);
                    end
                end
                step($urandom_range(0, 9) < 6, cv, ci,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 79) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rob_alloc.md
Name: rob_alloc

Overview:
- Front-end side of the reorder buffer. Hands out ROB slot indices in program order to decode/issue and tracks occupancy.
- Mirrors the ROB head, using one commit pulse per retired instruction, so it can free slots.
- Flags protocol violations, including completion of unallocated or already-completed slots.
- Sits between decode (requester) and the execution ports / ROB (consumers of robIdx).

Parameters:
- ROB_SLOTS, 16, number of ROB entries; must be a power of two.
- ROB_IDX_BITS, 4, log2(ROB_SLOTS).
- NUM_CPL_PORTS, 5, number of completion ports monitored (ports 0..4).
- ALMOST_FULL_TH, 2, almostFull asserts when free slots <= this value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clear  in  1  pipeline flush; same pulse that clears the ROB
- allocReq  in  1  decode requests one slot this cycle
- allocGrant  out  1  slot granted this cycle (combinational)
- allocIdx  out  ROB_IDX_BITS  index of the slot granted/offered (tail pointer)
- cplValid  in  NUM_CPL_PORTS  per-port completion strobe
- cplIdx  in  NUM_CPL_PORTS*ROB_IDX_BITS  per-port completed slot index, port k at bits [k*ROB_IDX_BITS +: ROB_IDX_BITS]
- commitValid  in  1  ROB retired its head entry this cycle
- headIdx  out  ROB_IDX_BITS  mirrored ROB head pointer
- headReady  out  1  head slot allocated and completed
- count  out  ROB_IDX_BITS+1  occupied slots
- full  out  1  count == ROB_SLOTS
- almostFull  out  1  ROB_SLOTS-count <= ALMOST_FULL_TH
- empty  out  1  count == 0
- protoErr  out  1  sticky protocol-error flag

Behaviour:
- State:
  - tail, head: ROB_IDX_BITS each.
  - count: ROB_IDX_BITS+1.
  - alloc[ROB_SLOTS] and done[ROB_SLOTS] bit vectors.
  - protoErr.
- Reset (rst=1 at posedge):
  - tail=0, head=0, count=0, alloc=0, done=0, protoErr=0.
  - Outputs: allocIdx=0, headIdx=0, full=0, almostFull=0, empty=1, headReady=0, allocGrant=0.
- Allocation:
  - allocGrant = allocReq & !full & !clear & !rst.
  - allocIdx = tail, always driven.
  - On grant: alloc[tail]<=1, done[tail]<=0, tail<=tail+1 mod ROB_SLOTS. Same-cycle latency; the index is valid in the grant cycle.
- Completion, each port k with cplValid[k]:
  - If alloc[idx]=1 and done[idx]=0: done[idx]<=1.
  - Otherwise: protoErr<=1 and the state for that slot is unchanged.
  - Two ports naming the same idx in one cycle: protoErr<=1; done[idx]<=1 if allocated.
- Commit, commitValid=1:
  - Required: count!=0 and alloc[head]&done[head]. If so: alloc[head]<=0, done[head]<=0, head<=head+1 mod ROB_SLOTS.
  - If violated: protoErr<=1 and no state change from the commit.
- headReady = alloc[head] & done[head].
- count update: count <= count + grant - validCommit.
  - Simultaneous grant and commit leaves count unchanged.
- Full handling:
  - full is decoded from registered count. No bypass: a commit in a cycle where full=1 does not enable a grant in the same cycle; the grant becomes possible next cycle.
- Wrap-around: tail and head wrap modulo ROB_SLOTS. tail==head is ambiguous, so full vs empty is resolved by count only.
- Completion to the slot being allocated in the same cycle: treated as unallocated, so protoErr is set.
- clear (when rst=0):
  - tail=0, head=0, count=0, alloc=0, done=0.
  - Same-cycle allocReq is not granted; same-cycle cplValid and commitValid are ignored.
  - protoErr is retained.
- rst dominates clear.
- protoErr is cleared only by rst.

Decomposition:
- Shared proc package holds ROB_SLOTS, ROB_IDX_BITS, ARCH_BITS and the completion-port count, also used by the ROB and execution ports.
- One sub-module is natural: rob_slot_tracker, the alloc/done bit vectors with NUM_CPL_PORTS set ports, one alloc set and one commit clear, plus duplicate/invalid detection.
- Pointer/count logic stays in the top module.

Test Plan:
- Reset, then 16 back-to-back allocReq:
  - allocIdx runs 0..15 with allocGrant=1 each cycle.
  - full=1 after cycle 16; 17th request gets allocGrant=0.
  - almostFull rises when count=14.
- Fill 3 slots (0,1,2), complete via cplValid[2] idx 1 then cplValid[0] idx 0:
  - headReady=1 after idx 0 completes.
  - commitValid -> headIdx=1, count=2; second commit -> headIdx=2.
- Full ROB with commitValid and allocReq in the same cycle:
  - No grant that cycle, count=15.
  - Next cycle grant with allocIdx=0 (wrap), count=16.
- Complete idx 5 while unallocated:
  - protoErr=1, remains 1 after clear, cleared only by rst.
- Complete idx 3 twice, and commit when empty: protoErr=1 in each case; head and count unchanged.
- Allocate 7 slots, then clear together with allocReq:
  - No grant; next cycle allocIdx=0, headIdx=0, count=0, empty=1.
